// File: rtl/joypad_responder.sv
// joypad_responder: console-side controller responder with debounced buttons and turbo.
//
// The raw button pins are synchronised and debounced per button. The debounced state
// (pressed) is optionally gated by a turbo phase for A and B. The result is latched into
// an 8-bit shift register while the console holds strobe high. It is then shifted out
// LSB-first on each joy_clock rise.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     async active-low reset
//   btn_n[7:0]  raw active-low buttons: A,B,Select,Start,Up,Down,Left,Right (bit 0..7)
//   turbo_en    [0] turbo on A, [1] turbo on B (quasi-static)
//   joy_strobe  console latch line (async)
//   joy_clock   console shift clock (async)
//   joy_data    serial data to console, active-low (0 = pressed), registered
//   pressed     debounced button state, active-high, before turbo gating

// Per-button debounce: a change is accepted only after it has been seen on
// DEBOUNCE_CYCLES consecutive cycles.
module joypad_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd21477
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level_i,    // synchronised, active-high
  output logic pressed_o
);
  logic [15:0] cnt_q, cnt_d;
  logic        pressed_q, pressed_d;

  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (level_i != pressed_q) begin
      if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) pressed_d = level_i;
      else                                  cnt_d     = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o = pressed_q;
endmodule

module joypad_responder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd21477,
  parameter logic [3:0]  TURBO_FRAMES    = 4'd3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] btn_n,
  input  logic [1:0] turbo_en,
  input  logic       joy_strobe,
  input  logic       joy_clock,
  output logic       joy_data,
  output logic [7:0] pressed
);
  localparam int NUM_BTNS = 8;

  // Synchronisers. The strobe/clock chains carry a third flop that holds the
  // previous synchronised level for edge detection.
  logic [7:0] btn_s1_q, btn_s2_q;
  logic [2:0] stb_q, jck_q;
  logic       stb_s2, stb_rise, jck_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q <= 8'hFF;
      btn_s2_q <= 8'hFF;
      stb_q    <= '0;
      jck_q    <= '0;
    end else begin
      btn_s1_q <= btn_n;
      btn_s2_q <= btn_s1_q;
      stb_q    <= {stb_q[1:0], joy_strobe};
      jck_q    <= {jck_q[1:0], joy_clock};
    end
  end

  assign stb_s2   = stb_q[1];
  assign stb_rise = stb_q[1] & ~stb_q[2];
  assign jck_rise = jck_q[1] & ~jck_q[2];

  // Debounce, one instance per button.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    joypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock     (clock),
      .reset_n   (reset_n),
      .level_i   (~btn_s2_q[i]),
      .pressed_o (pressed[i])
    );
  end

  // Turbo: phase flips every TURBO_FRAMES strobe rises. On the rise cycle the
  // load still sees the old phase, so a one-cycle strobe reports the pre-toggle value.
  logic [3:0] div_q, div_d;
  logic       phase_q, phase_d;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (stb_rise) begin
      if (div_q >= TURBO_FRAMES - 4'd1) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d   = div_q + 4'd1;
      end
    end
  end

  logic [7:0] eff;
  always_comb begin
    eff    = pressed;
    eff[0] = pressed[0] & (~turbo_en[0] | phase_q);
    eff[1] = pressed[1] & (~turbo_en[1] | phase_q);
  end

  // Shift register. Strobe level has priority over a coincident clock rise.
  // After 8 shifts the line is forced low (reads as pressed) until the next strobe.
  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       jd_q, jd_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    jd_d  = jd_q;
    if (stb_s2) begin
      sr_d  = eff;
      cnt_d = '0;
      jd_d  = ~eff[0];
    end else if (jck_rise) begin
      sr_d  = {1'b0, sr_q[7:1]};
      cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
      jd_d  = (cnt_d == 4'd8) ? 1'b0 : ~sr_d[0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      jd_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      jd_q    <= jd_d;
    end
  end

  assign joy_data = jd_q;
endmodule
